rr_logic_unit_arbiter: RTL and testbench
========================================

Name: rr_logic_unit_arbiter

Overview:
- Shares one mux-built bitwise logic unit among N_REQ requesters using round-robin arbitration.
- Each requester issues (a, b, op) with a valid/ready handshake.
- The arbiter grants one request per accept cycle and registers the unit's result with the requester ID.
- The result is held until the single consumer takes it.
- Sits between several combinational-homework style clients and a single shared mux-based gate datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  one-hot (or zero) grant/accept strobe.
- req_a  input  N_REQ*W  operand A, packed, requester i at [i*W +: W].
- req_b  input  N_REQ*W  operand B, packed likewise.
- req_op  input  N_REQ*2  op code per requester: 0 AND, 1 OR, 2 XOR, 3 XNOR.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  W  registered result.
- res_id  output  ID_W  index of the requester that produced res_data.
- busy_cnt  output  16  saturating count of accepted requests since reset.

Behaviour:
- Reset (async, rst=1):
  - res_valid=0, res_data=0, res_id=0, busy_cnt=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has highest priority first.
  - req_ready=0 while rst is high.
- Accept condition: can_accept = !res_valid || res_ready. req_ready is combinational and asserted for exactly one index g only when can_accept=1 and req_valid[g]=1.
- Grant choice: g = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo N_REQ. Wrap-around is required: with last_grant=N_REQ-1 the search starts at 0.
- On an accept edge (req_valid[g] && req_ready[g]):
  - res_data <= unit(req_a[g], req_b[g], req_op[g]); res_id <= g; res_valid <= 1.
  - last_grant <= g; busy_cnt <= busy_cnt+1, saturating at 16'hFFFF.
- Latency: result is visible the cycle after acceptance. Throughput is 1 per cycle while res_ready=1.
- Result handshake:
  - res_ready=1 with res_valid=1 and no new accept: res_valid <= 0.
  - Simultaneous consume and accept: res_valid stays 1 and data is replaced by the new result, with no bubble.
- Back-pressure: res_valid=1 and res_ready=0 gives all req_ready=0; res_data and res_id hold stable.
- No requests: last_grant is unchanged and res_valid follows the consume rule.
- Requesters must hold req_a/req_b/req_op stable while req_valid=1 and not yet granted. A requester dropping valid before grant is tolerated; it is simply not chosen.
- Unused ID encodings and N_REQ not a power of two: the search never yields an index ≥ N_REQ.
- Reset mid-operation: any held result is discarded and no grant is issued in the reset cycle.
- Two-state FSM implied by res_valid:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with consume.
  - FULL → EMPTY on consume without accept.

Decomposition:
- Package logic_unit_pkg:
  - typedef enum logic [1:0] op_t {OP_AND, OP_OR, OP_XOR, OP_XNOR}.
  - localparam for busy_cnt width.
- Sub-module logic_unit_mux (combinational, W-bit):
  - Each bit is built only from 2:1 mux instances and constants, per bit: and=sel a?b:0, or=sel a?1:b, xor=sel a?~b:b, with ~b itself a mux(1,0,b).
  - A final 4:1 mux tree selects the op.
- Arbiter RTL instantiates one logic_unit_mux fed by the granted requester's operands.

Test Plan:
1. Reset, then single request: req_valid=4'b0001, a=8'hF0, b=8'h3C, op=XOR. Requires req_ready[0]=1 in that cycle; next cycle res_valid=1, res_data=8'hCC, res_id=0, busy_cnt=1.
2. All-op check on requester 2: a=8'hA5, b=8'h0F. AND→8'h05, OR→8'hAF, XOR→8'hAA, XNOR→8'h55, all with res_id=2.
3. Round-robin fairness: req_valid=4'b1111 held, res_ready=1 for 8 cycles. Grants must be 0,1,2,3,0,1,2,3 with one result per cycle.
4. Wrap/skip: last grant=2, req_valid=4'b0011. Next grant must be 0, then 1, then 0.
5. Back-pressure: res_ready=0 while res_valid=1 and requests are pending. Requires req_ready=0, res_data/res_id stable for 5 cycles; on res_ready=1 the same-cycle accept replaces the result with no bubble.
6. Async reset mid-stream: assert rst between edges while res_valid=1. Outputs clear immediately (res_valid=0, busy_cnt=0); after release, the first grant goes to the lowest-index active requester.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the round-robin logic-unit arbiter.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_t;

    // Result slot occupancy; mirrors res_valid.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } res_state_t;

    localparam int unsigned BUSY_CNT_W = 16;

endpackage

// File: rtl/logic_unit_mux.sv
// Bitwise AND/OR/XOR/XNOR unit built purely from 2:1 muxes and constants.
module logic_unit_mux
    import logic_unit_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  op_t          i_op,
    output logic [W-1:0] o_y
);

    logic [W-1:0] w_nb;
    logic [W-1:0] w_and;
    logic [W-1:0] w_or;
    logic [W-1:0] w_xor;
    logic [W-1:0] w_xnor;
    logic [W-1:0] w_lo;
    logic [W-1:0] w_hi;

    for (genvar i = 0; i < W; i++) begin : g_bit
        // Inverter as a mux between constants.
        assign w_nb[i]   = i_b[i] ? 1'b0 : 1'b1;
        assign w_and[i]  = i_a[i] ? i_b[i] : 1'b0;
        assign w_or[i]   = i_a[i] ? 1'b1 : i_b[i];
        assign w_xor[i]  = i_a[i] ? w_nb[i] : i_b[i];
        assign w_xnor[i] = i_a[i] ? i_b[i] : w_nb[i];
        // 4:1 tree: op[0] picks within each pair, op[1] picks the pair.
        assign w_lo[i]   = i_op[0] ? w_or[i] : w_and[i];
        assign w_hi[i]   = i_op[0] ? w_xnor[i] : w_xor[i];
        assign o_y[i]    = i_op[1] ? w_hi[i] : w_lo[i];
    end

endmodule

// File: rtl/rr_logic_unit_arbiter.sv
// Round-robin arbiter sharing one mux-based logic unit among N_REQ requesters.
module rr_logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*W-1:0]    req_a,
    input  logic [N_REQ*W-1:0]    req_b,
    input  logic [N_REQ*2-1:0]    req_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [W-1:0]          res_data,
    output logic [ID_W-1:0]       res_id,
    output logic [BUSY_CNT_W-1:0] busy_cnt
);

    res_state_t            r_state;
    res_state_t            w_state_next;
    logic [ID_W-1:0]       r_last_grant;
    logic [W-1:0]          r_res_data;
    logic [ID_W-1:0]       r_res_id;
    logic [BUSY_CNT_W-1:0] r_busy_cnt;

    logic                  w_can_accept;
    logic                  w_found;
    logic [ID_W-1:0]       w_grant;
    logic                  w_accept;
    logic [W-1:0]          w_sel_a;
    logic [W-1:0]          w_sel_b;
    op_t                   w_sel_op;
    logic [W-1:0]          w_unit_y;

    assign w_can_accept = (r_state == StEmpty) || res_ready;

    // Search requesters starting just after the last grant, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int idx;
            idx = (int'(r_last_grant) + k) % int'(N_REQ);
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_grant = ID_W'(idx);
            end
        end
    end

    // One-hot grant strobe; suppressed during reset and while the result is blocked.
    always_comb begin
        req_ready = '0;
        if (!rst && w_can_accept && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept = |req_ready;

    // Route the granted requester's operands to the shared unit.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = OP_AND;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_a  = req_a[i*W +: W];
                w_sel_b  = req_b[i*W +: W];
                w_sel_op = op_t'(req_op[i*2 +: 2]);
            end
        end
    end

    logic_unit_mux #(
        .W (W)
    ) u_unit (
        .i_a  (w_sel_a),
        .i_b  (w_sel_b),
        .i_op (w_sel_op),
        .o_y  (w_unit_y)
    );

    // Result slot next state: fill on accept, drain on consume without accept.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = StFull;
        end else if (res_ready) begin
            w_state_next = StEmpty;
        end
    end

    // Result slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the result, its source, the round-robin pointer and the accept count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data   <= '0;
            r_res_id     <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_busy_cnt   <= '0;
        end else if (w_accept) begin
            r_res_data   <= w_unit_y;
            r_res_id     <= w_grant;
            r_last_grant <= w_grant;
            if (r_busy_cnt != '1) begin
                r_busy_cnt <= r_busy_cnt + BUSY_CNT_W'(1);
            end
        end
    end

    assign res_valid = (r_state == StFull);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_rr_logic_unit_arbiter.sv
// Self-checking bench for rr_logic_unit_arbiter (N_REQ=4, W=8).
module tb_rr_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic [15:0] busy_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_id;
    int          m_last;
    int          m_cnt;

    always #5 clk = ~clk;

    rr_logic_unit_arbiter #(
        .N_REQ (4),
        .W     (8),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy_cnt  (busy_cnt)
    );

    function automatic logic [7:0] m_unit(logic [7:0] a, logic [7:0] b, logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic int m_pick(logic [3:0] v, int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready(logic [3:0] v, int last, logic full, logic rr);
        logic [3:0] r;
        int g;
        r = '0;
        g = m_pick(v, last);
        if ((!full || rr) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_last  = 3;
        m_cnt   = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int g;
        g = m_pick(req_valid, m_last);
        if ((!m_valid || res_ready) && g >= 0) begin
            m_data  = m_unit(req_a[g*8 +: 8], req_b[g*8 +: 8], req_op[g*2 +: 2]);
            m_id    = g;
            m_valid = 1'b1;
            m_last  = g;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [1:0] op);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_op[i*2 +: 2] = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 2'd0 || busy_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h id=%0d cnt=%0d want 0/00/0/0",
                     res_valid, res_data, res_id, busy_cnt);
        end
        rst = 1'b0;
        req_valid = '0;
        tick();
        model_reset();
    endtask

    task automatic test_single();
        set_req(0, 8'hF0, 8'h3C, 2'd2);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b want=0001", req_ready);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hCC || res_id !== 2'd0 || busy_cnt !== 16'd1) begin
            failures++;
            $display("FAIL single_result got v=%b d=%h id=%0d cnt=%0d want 1/cc/0/1",
                     res_valid, res_data, res_id, busy_cnt);
        end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_tab [4];
        exp_tab = '{8'h05, 8'hAF, 8'hAA, 8'h55};
        req_valid = 4'b0100;
        res_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            set_req(2, 8'hA5, 8'h0F, 2'(op));
            #1;
            checks++;
            if (req_ready !== 4'b0100) begin
                failures++;
                $display("FAIL ops_ready op=%0d got=%b want=0100", op, req_ready);
            end
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_tab[op] || res_id !== 2'd2) begin
                failures++;
                $display("FAIL ops_result op=%0d got v=%b d=%h id=%0d want 1/%h/2",
                         op, res_valid, res_data, res_id, exp_tab[op]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i * 17), 8'h5A, 2'(i));
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_r;
            exp_r = '0;
            exp_r[k % 4] = 1'b1;
            #1;
            checks++;
            if (req_ready !== exp_r) begin
                failures++;
                $display("FAIL rr_ready k=%0d got=%b want=%b", k, req_ready, exp_r);
            end
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(k % 4)
                || res_data !== m_unit(8'((k % 4) * 17), 8'h5A, 2'(k % 4))) begin
                failures++;
                $display("FAIL rr_result k=%0d got v=%b id=%0d d=%h want id=%0d",
                         k, res_valid, res_id, res_data, k % 4);
            end
        end
    endtask

    task automatic test_wrap_skip();
        int exp_id [3];
        exp_id = '{0, 1, 0};
        req_valid = 4'b0100;
        tick();
        set_req(0, 8'h12, 8'h34, 2'd1);
        set_req(1, 8'h77, 8'h0F, 2'd0);
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] exp_r;
            exp_r = '0;
            exp_r[exp_id[k]] = 1'b1;
            #1;
            checks++;
            if (req_ready !== exp_r) begin
                failures++;
                $display("FAIL wrap_ready k=%0d got=%b want=%b", k, req_ready, exp_r);
            end
            tick();
            checks++;
            if (res_id !== 2'(exp_id[k])) begin
                failures++;
                $display("FAIL wrap_id k=%0d got=%0d want=%0d", k, res_id, exp_id[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        // Held result is requester 0: 8'h12 | 8'h34.
        set_req(1, 8'hC3, 8'h99, 2'd2);
        req_valid = 4'b1111;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ready k=%0d got=%b want=0000", k, req_ready);
            end
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h36 || res_id !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold k=%0d got v=%b d=%h id=%0d want 1/36/0",
                         k, res_valid, res_data, res_id);
            end
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_ready got=%b want=0010", req_ready);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'h5A || busy_cnt !== 16'd13) begin
            failures++;
            $display("FAIL bp_release got v=%b id=%0d d=%h cnt=%0d want 1/1/5a/13",
                     res_valid, res_id, res_data, busy_cnt);
        end
    endtask

    task automatic test_async_reset();
        req_valid = 4'b1111;
        res_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy_cnt !== 16'd0 || res_data !== 8'h00 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL async_clear got v=%b cnt=%0d d=%h rdy=%b want 0/0/00/0000",
                     res_valid, busy_cnt, res_data, req_ready);
        end
        #2;
        rst = 1'b0;
        set_req(1, 8'h0F, 8'hFF, 2'd3);
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL async_first_grant got=%b want=0010", req_ready);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'h0F || busy_cnt !== 16'd1) begin
            failures++;
            $display("FAIL async_after got v=%b id=%0d d=%h cnt=%0d want 1/1/0f/1",
                     res_valid, res_id, res_data, busy_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            logic [3:0] exp_r;
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_op    = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = m_ready(req_valid, m_last, m_valid, res_ready);
            checks++;
            if (req_ready !== exp_r) begin
                failures++;
                $display("FAIL rand_ready k=%0d got=%b want=%b", k, req_ready, exp_r);
            end
            model_edge();
            tick();
            checks++;
            if (res_valid !== m_valid || busy_cnt !== 16'(m_cnt)
                || (m_valid && (res_data !== m_data || res_id !== 2'(m_id)))) begin
                failures++;
                $display("FAIL rand_result k=%0d got v=%b d=%h id=%0d cnt=%0d want v=%b d=%h id=%0d cnt=%0d",
                         k, res_valid, res_data, res_id, busy_cnt, m_valid, m_data, m_id, m_cnt);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        res_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_all_ops();
        test_round_robin();
        test_wrap_skip();
        test_back_pressure();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
